// File: rtl/flush_queue_pkg.sv
// Shared definitions for the flush queue: payload type and pointer/counter width helpers.
package flush_queue_pkg;

    localparam int GPREG_W = 32;

    typedef logic [GPREG_W-1:0] gpreg_t;

    // Pointer width for an n-entry ring; a single-entry ring still gets one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Counter width able to hold every value 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/flush_queue_chk.sv
// Protocol checker: a handshake must never push a full queue or pop an empty one.
module flush_queue_chk (
    input logic i_clk,
    input logic i_rst,
    input logic i_enq_fire,
    input logic i_deq_fire,
    input logic i_full,
    input logic i_empty,
    input logic i_bypass
);

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_enq_fire && i_full && !i_deq_fire));

    a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_deq_fire && i_empty && !i_bypass));

endmodule

// File: rtl/flush_queue_wrap_ctr.sv
// Modulo-MAX pointer: wraps from MAX-1 back to 0 explicitly, clearable in one cycle.
module flush_queue_wrap_ctr
    import flush_queue_pkg::*;
#(
    parameter  int MAX = 2,
    localparam int W   = idx_width(MAX)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_value
);

    logic [W-1:0] r_value;

    // Pointer state; reset beats clear, clear beats increment.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_value <= {W{1'b0}};
        end else if (i_clr) begin
            r_value <= {W{1'b0}};
        end else if (i_inc) begin
            r_value <= (r_value == W'(MAX - 1)) ? {W{1'b0}} : r_value + W'(1);
        end else begin
            r_value <= r_value;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/flush_queue.sv
// Arbitrary-depth valid/ready FIFO with single-cycle flush, occupancy count,
// optional empty-queue fallthrough and optional full-queue pipe replace.
module flush_queue
    import flush_queue_pkg::*;
#(
    parameter  int DATA_W      = GPREG_W,
    parameter  int DEPTH       = 2,
    parameter  bit FALLTHROUGH = 1'b0,
    parameter  bit PIPE        = 1'b0,
    localparam int IDX_W       = idx_width(DEPTH),
    localparam int CNT_W       = cnt_width(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_enq_valid,
    output logic              o_enq_ready,
    input  logic [DATA_W-1:0] i_enq_data,
    output logic              o_deq_valid,
    input  logic              i_deq_ready,
    output logic [DATA_W-1:0] o_deq_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_store [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [IDX_W-1:0]  w_head;
    logic [IDX_W-1:0]  w_tail;

    logic w_full;
    logic w_empty;
    logic w_enq_ready;
    logic w_deq_valid;
    logic w_enq_fire;
    logic w_deq_fire;
    logic w_bypass;
    logic w_do_write;
    logic w_do_read;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == {CNT_W{1'b0}});

    // Flush gates both handshakes so nothing moves during the discard cycle.
    assign w_enq_ready = !i_flush && (!w_full || (PIPE && i_deq_ready));
    assign w_deq_valid = !i_flush && (!w_empty || (FALLTHROUGH && i_enq_valid));

    assign w_enq_fire = i_enq_valid && w_enq_ready;
    assign w_deq_fire = w_deq_valid && i_deq_ready;

    // An empty fallthrough queue hands the word straight across without touching storage.
    assign w_bypass   = FALLTHROUGH && w_empty && w_enq_fire && w_deq_fire;
    assign w_do_write = w_enq_fire && !w_bypass;
    assign w_do_read  = w_deq_fire && !w_bypass;

    flush_queue_wrap_ctr #(.MAX(DEPTH)) u_head (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_flush),
        .i_inc   (w_do_read),
        .o_value (w_head)
    );

    flush_queue_wrap_ctr #(.MAX(DEPTH)) u_tail (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_flush),
        .i_inc   (w_do_write),
        .o_value (w_tail)
    );

    // Storage is deliberately not reset; only accepted writes land.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_do_write) begin
            r_store[w_tail] <= i_enq_data;
        end
    end

    // Occupancy tracks net writes minus reads; reset and flush both empty it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_flush) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            case ({w_do_write, w_do_read})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_enq_ready = w_enq_ready;
    assign o_deq_valid = w_deq_valid;
    assign o_deq_data  = (FALLTHROUGH && w_empty) ? i_enq_data : r_store[w_head];
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;

    flush_queue_chk u_chk (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_enq_fire (w_enq_fire),
        .i_deq_fire (w_deq_fire),
        .i_full     (w_full),
        .i_empty    (w_empty),
        .i_bypass   (w_bypass)
    );

endmodule

// File: tb/tb_flush_queue.sv
// Three queue flavours (DEPTH=3 plain, DEPTH=2 fallthrough, DEPTH=2 pipe) share one
// stimulus stream and are each compared every cycle against a list-based model.
module tb_flush_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fl  = 1'b0;
    logic        ev  = 1'b1;
    logic        dr  = 1'b0;
    logic [31:0] ed  = 32'h0000_00AA;

    logic        er  [3];
    logic        dv  [3];
    logic [31:0] dd  [3];
    logic [1:0]  cnt [3];
    logic        fu  [3];
    logic        em  [3];

    int          m_depth [3] = '{3, 2, 2};
    bit          m_ft    [3] = '{1'b0, 1'b1, 1'b0};
    bit          m_pipe  [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] m_q     [3][4];
    int          m_n     [3] = '{0, 0, 0};
    bit          m_known = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    flush_queue #(.DATA_W(32), .DEPTH(3), .FALLTHROUGH(1'b0), .PIPE(1'b0)) u_d3 (
        .i_clk(clk), .i_rst(rst), .i_flush(fl), .i_enq_valid(ev), .o_enq_ready(er[0]),
        .i_enq_data(ed), .o_deq_valid(dv[0]), .i_deq_ready(dr), .o_deq_data(dd[0]),
        .o_count(cnt[0]), .o_full(fu[0]), .o_empty(em[0]));

    flush_queue #(.DATA_W(32), .DEPTH(2), .FALLTHROUGH(1'b1), .PIPE(1'b0)) u_ft (
        .i_clk(clk), .i_rst(rst), .i_flush(fl), .i_enq_valid(ev), .o_enq_ready(er[1]),
        .i_enq_data(ed), .o_deq_valid(dv[1]), .i_deq_ready(dr), .o_deq_data(dd[1]),
        .o_count(cnt[1]), .o_full(fu[1]), .o_empty(em[1]));

    flush_queue #(.DATA_W(32), .DEPTH(2), .FALLTHROUGH(1'b0), .PIPE(1'b1)) u_pp (
        .i_clk(clk), .i_rst(rst), .i_flush(fl), .i_enq_valid(ev), .o_enq_ready(er[2]),
        .i_enq_data(ed), .o_deq_valid(dv[2]), .i_deq_ready(dr), .o_deq_data(dd[2]),
        .o_count(cnt[2]), .o_full(fu[2]), .o_empty(em[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: each queue is an ordered list; outputs follow from its length and the inputs.
    always @(negedge clk) begin : cmp
        for (int k = 0; k < 3; k++) begin
            bit e_full, e_empty, e_er, e_dv, e_ef, e_df;
            e_full  = (m_n[k] == m_depth[k]);
            e_empty = (m_n[k] == 0);
            e_er    = !fl && (!e_full || (m_pipe[k] && dr));
            e_dv    = !fl && (!e_empty || (m_ft[k] && ev));
            if (m_known) begin
                chk($sformatf("count[%0d]", k), 32'(cnt[k]), 32'(m_n[k]));
                chk($sformatf("full[%0d]", k), 32'(fu[k]), 32'(e_full));
                chk($sformatf("empty[%0d]", k), 32'(em[k]), 32'(e_empty));
                chk($sformatf("enq_ready[%0d]", k), 32'(er[k]), 32'(e_er));
                chk($sformatf("deq_valid[%0d]", k), 32'(dv[k]), 32'(e_dv));
                if (e_dv) chk($sformatf("deq_data[%0d]", k), dd[k], e_empty ? ed : m_q[k][0]);
            end
            e_ef = ev && e_er;
            e_df = e_dv && dr;
            if (rst) begin
                m_n[k] = 0;
            end else if (m_known) begin
                if (fl) begin
                    m_n[k] = 0;
                end else if (!(e_empty && e_ef && e_df)) begin
                    if (e_df) begin
                        for (int j = 0; j < 3; j++) m_q[k][j] = m_q[k][j+1];
                        m_n[k]--;
                    end
                    if (e_ef) begin
                        m_q[k][m_n[k]] = ed;
                        m_n[k]++;
                    end
                end
            end
        end
        if (rst) m_known = 1'b1;
    end

    task automatic cyc(input logic r, input logic f, input logic v,
                       input logic [31:0] d, input logic rdy);
        @(posedge clk);
        #1;
        rst = r; fl = f; ev = v; ed = d; dr = rdy;
        @(negedge clk);
    endtask

    initial begin
        // reset held two cycles with a pending producer
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_00AA, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_00AA, 1'b0);
        chk("rst_count", 32'(cnt[0]), 32'd0);
        chk("rst_empty", 32'(em[0]), 32'd1);
        chk("rst_enq_ready", 32'(er[0]), 32'd1);

        // fill DEPTH=3 with A,B,C
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_000A, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_000B, 1'b0);
        chk("fill_count1", 32'(cnt[0]), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_000C, 1'b0);
        chk("fill_count2", 32'(cnt[0]), 32'd2);
        chk("pipe_full", 32'(fu[2]), 32'd1);
        chk("pipe_ready_noreq", 32'(er[2]), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("fill_count3", 32'(cnt[0]), 32'd3);
        chk("fill_full", 32'(fu[0]), 32'd1);
        chk("fill_enq_ready", 32'(er[0]), 32'd0);

        // drain A,B,C; pipe queue replaces while full
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_000D, 1'b1);
        chk("pop_a", dd[0], 32'h0000_000A);
        chk("pipe_ready_full", 32'(er[2]), 32'd1);
        chk("pipe_pop_a", dd[2], 32'h0000_000A);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("pop_b", dd[0], 32'h0000_000B);
        chk("pipe_count_hold", 32'(cnt[2]), 32'd2);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("pop_c", dd[0], 32'h0000_000C);
        chk("pop_c_count", 32'(cnt[0]), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0066, 1'b0);
        chk("drained_empty", 32'(em[0]), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_count", 32'(cnt[0]), 32'd1);
        chk("wrap_data", dd[0], 32'h0000_0066);

        // fallthrough bypass on an empty queue
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0055, 1'b1);
        chk("ft_valid", 32'(dv[1]), 32'd1);
        chk("ft_data", dd[1], 32'h0000_0055);
        chk("ft_count_now", 32'(cnt[1]), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("ft_count_after", 32'(cnt[1]), 32'd0);

        // flush with both sides requesting
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0101, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0102, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b1);
        chk("flush_count_before", 32'(cnt[0]), 32'd2);
        chk("flush_enq_ready", 32'(er[0]), 32'd0);
        chk("flush_deq_valid", 32'(dv[0]), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("flush_count_after", 32'(cnt[0]), 32'd0);
        chk("flush_empty_after", 32'(em[0]), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0077, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("post_flush_valid", 32'(dv[0]), 32'd1);
        chk("post_flush_data", dd[0], 32'h0000_0077);

        // steady streaming at occupancy 2
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0201, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 32'h0000_0300 + 32'(i), 1'b1);
            chk("stream_count", 32'(cnt[0]), 32'd2);
        end

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 300) == 0, ($urandom % 20) == 0, ($urandom % 4) != 0,
                $urandom, ($urandom % 3) != 0);
        end

        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
